// File: rtl/bit_unstuffing_if.sv
// Serial receive bus between the NRZI decoder, the unstuffer and the byte/CRC checker.
// The master drives the packet window and raw bits; the slave returns the unstuffed stream.
interface bit_unstuffing_if;
    logic       data_in;
    logic       en_data;
    logic       data_out;
    logic       bit_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_frag;
    logic       stuff_err;

    modport master (
        output data_in, en_data,
        input  data_out, bit_valid, byte_out, byte_valid, byte_frag, stuff_err
    );

    modport slave (
        input  data_in, en_data,
        output data_out, bit_valid, byte_out, byte_valid, byte_frag, stuff_err
    );
endinterface

// File: rtl/bit_unstuffing.sv
// Removes the zero stuffed after every RUN_LEN consecutive ones, flags stuffing
// violations and assembles surviving bits (LSB first) into bytes.
module bit_unstuffing #(
    parameter int RUN_LEN = 6
) (
    input logic             clk,
    input logic             rst,
    bit_unstuffing_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DATA, SKIP, ERR} state_t;

    localparam logic [2:0] RUN_LAST = 3'(RUN_LEN - 1);
    localparam logic [2:0] RUN_FULL = 3'(RUN_LEN);

    state_t     state, state_nxt;
    logic [2:0] ones_cnt, ones_nxt;
    logic [2:0] bit_idx, idx_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [7:0] byte_reg, byte_nxt;
    logic [7:0] shifted;
    logic       dout, dout_nxt;
    logic       bv, bv_nxt;
    logic       byv, byv_nxt;
    logic       frag, frag_nxt;
    logic       err, err_nxt;
    logic       pass;

    assign shifted = {bus.data_in, shreg[7:1]};

    always_comb begin
        state_nxt = state;
        ones_nxt  = ones_cnt;
        idx_nxt   = bit_idx;
        shreg_nxt = shreg;
        byte_nxt  = byte_reg;
        dout_nxt  = 1'b1;
        bv_nxt    = 1'b0;
        byv_nxt   = 1'b0;
        frag_nxt  = 1'b0;
        err_nxt   = err;
        pass      = 1'b0;

        if (!bus.en_data) begin
            // Packet boundary: drop any partial byte and report it as a fragment.
            if (state != IDLE) begin
                state_nxt = IDLE;
                ones_nxt  = 3'd0;
                idx_nxt   = 3'd0;
                shreg_nxt = 8'h00;
                err_nxt   = 1'b0;
                frag_nxt  = ((state == DATA) || (state == SKIP)) && (bit_idx != 3'd0);
            end
        end else begin
            unique case (state)
                IDLE, DATA: begin
                    pass      = 1'b1;
                    state_nxt = DATA;
                    if (!bus.data_in) begin
                        ones_nxt = 3'd0;
                    end else if (ones_cnt < RUN_LAST) begin
                        ones_nxt = ones_cnt + 3'd1;
                    end else begin
                        ones_nxt  = RUN_FULL;
                        state_nxt = SKIP;
                    end
                end
                SKIP: begin
                    if (!bus.data_in) begin
                        ones_nxt  = 3'd0;
                        state_nxt = DATA;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ERR;
                    end
                end
                ERR: begin
                    state_nxt = ERR;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            if (pass) begin
                dout_nxt  = bus.data_in;
                bv_nxt    = 1'b1;
                shreg_nxt = shifted;
                if (bit_idx == 3'd7) begin
                    byte_nxt = shifted;
                    byv_nxt  = 1'b1;
                    idx_nxt  = 3'd0;
                end else begin
                    idx_nxt = bit_idx + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ones_cnt <= 3'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            byte_reg <= 8'h00;
            dout     <= 1'b1;
            bv       <= 1'b0;
            byv      <= 1'b0;
            frag     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            ones_cnt <= ones_nxt;
            bit_idx  <= idx_nxt;
            shreg    <= shreg_nxt;
            byte_reg <= byte_nxt;
            dout     <= dout_nxt;
            bv       <= bv_nxt;
            byv      <= byv_nxt;
            frag     <= frag_nxt;
            err      <= err_nxt;
        end
    end

    assign bus.data_out   = dout;
    assign bus.bit_valid  = bv;
    assign bus.byte_out   = byte_reg;
    assign bus.byte_valid = byv;
    assign bus.byte_frag  = frag;
    assign bus.stuff_err  = err;

endmodule

// File: tb/tb_bit_unstuffing.sv
// Bench for bit_unstuffing: directed and random packets, scoreboard queues filled by a
// packet-level reference model and drained by a negedge monitor.
module tb_bit_unstuffing;

    localparam int RUN_LEN = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit_unstuffing_if bus ();

    bit_unstuffing #(.RUN_LEN(RUN_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic       exp_bit_q[$];
    logic [7:0] exp_byte_q[$];
    int         frag_q[$];
    int         err_q[$];
    logic [7:0] last_byte = 8'h00;
    logic       prev_err  = 1'b0;

    logic pkt[$];
    int   enc_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Reference: walk the samples, drop the zero after each RUN_LEN ones, stop at a violation.
    task automatic model(input int upto, input bit ends_normally);
        int   run;
        bit   skip;
        bit   err;
        logic surv[$];
        logic [7:0] b;
        run  = 0;
        skip = 1'b0;
        err  = 1'b0;
        for (int i = 0; i < upto; i++) begin
            if (err) continue;
            if (skip) begin
                if (pkt[i]) begin
                    err = 1'b1;
                    err_q.push_back(1);
                end else begin
                    skip = 1'b0;
                    run  = 0;
                end
                continue;
            end
            surv.push_back(pkt[i]);
            run = pkt[i] ? run + 1 : 0;
            if (run == RUN_LEN) skip = 1'b1;
        end
        foreach (surv[i]) exp_bit_q.push_back(surv[i]);
        for (int k = 0; k + 8 <= surv.size(); k += 8) begin
            for (int j = 0; j < 8; j++) b[j] = surv[k + j];
            exp_byte_q.push_back(b);
        end
        if (ends_normally && !err && (surv.size() % 8 != 0)) frag_q.push_back(1);
    endtask

    task automatic new_pkt();
        pkt.delete();
        enc_run = 0;
    endtask

    // Transmit-side stuffing used to build legal packets.
    task automatic push_raw(input logic b);
        pkt.push_back(b);
        enc_run = b ? enc_run + 1 : 0;
        if (enc_run == RUN_LEN) begin
            pkt.push_back(1'b0);
            enc_run = 0;
        end
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) push_raw(v[i]);
    endtask

    task automatic load(input logic [63:0] v, input int n);
        new_pkt();
        for (int i = 0; i < n; i++) pkt.push_back(v[i]);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data_out"},   32'(bus.data_out),   32'd1);
        check({tag, "_bit_valid"},  32'(bus.bit_valid),  32'd0);
        check({tag, "_byte_out"},   32'(bus.byte_out),   32'h00);
        check({tag, "_byte_valid"}, 32'(bus.byte_valid), 32'd0);
        check({tag, "_byte_frag"},  32'(bus.byte_frag),  32'd0);
        check({tag, "_stuff_err"},  32'(bus.stuff_err),  32'd0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_bits_left"},  32'(exp_bit_q.size()),  32'd0);
        check({tag, "_bytes_left"}, 32'(exp_byte_q.size()), 32'd0);
        check({tag, "_frags_left"}, 32'(frag_q.size()),     32'd0);
        check({tag, "_errs_left"},  32'(err_q.size()),      32'd0);
    endtask

    // Drive pkt; rst_at >= 0 pulses rst (with en_data still high) before that sample.
    task automatic run_pkt(input int rst_at, input int gap);
        int n;
        n = (rst_at >= 0 && rst_at < pkt.size()) ? rst_at : pkt.size();
        model(n, rst_at < 0);
        for (int i = 0; i < n; i++) begin
            bus.data_in = pkt[i];
            bus.en_data = 1'b1;
            @(posedge clk);
            #1;
        end
        if (rst_at >= 0) begin
            rst         = 1'b1;
            bus.en_data = 1'b1;
            bus.data_in = 1'($urandom);
            @(posedge clk);
            #1;
            check_reset_vals("mid_rst");
            check_drained("mid_rst");
            rst         = 1'b0;
            bus.en_data = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            bus.en_data = 1'b0;
            bus.data_in = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            #1;
            check("eop_stuff_err", 32'(bus.stuff_err), 32'd0);
            check("eop_byte_hold", 32'(bus.byte_out), 32'(last_byte));
            check_drained("eop");
        end
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) last_byte = 8'h00;
        if (bus.bit_valid) begin
            if (exp_bit_q.size() == 0) unexpected("bit_valid");
            else check("data_out", 32'(bus.data_out), 32'(exp_bit_q.pop_front()));
        end
        if (bus.byte_valid) begin
            if (exp_byte_q.size() == 0) unexpected("byte_valid");
            else begin
                last_byte = exp_byte_q.pop_front();
                check("byte_out", 32'(bus.byte_out), 32'(last_byte));
            end
        end
        if (bus.byte_frag) begin
            if (frag_q.size() == 0) unexpected("byte_frag");
            else begin
                void'(frag_q.pop_front());
                check("frag_byte_hold", 32'(bus.byte_out), 32'(last_byte));
            end
        end
        if (bus.stuff_err && !prev_err) begin
            if (err_q.size() == 0) unexpected("stuff_err");
            else begin
                void'(err_q.pop_front());
                check("stuff_err_rise", 32'(bus.stuff_err), 32'd1);
            end
        end
        prev_err = bus.stuff_err;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        int len;
        bus.data_in = 1'b0;
        bus.en_data = 1'b0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // Eight zeros: one byte 0x00.
        load(64'h0, 8);
        run_pkt(-1, 0);
        // Six ones, stuffed zero, two ones: byte 0xFF.
        load(64'h1BF, 9);
        run_pkt(-1, 1);
        // Seven ones: violation, remaining bits ignored.
        load(64'h57F, 11);
        run_pkt(-1, 0);
        // Five bits then end: fragment.
        load(64'h15, 5);
        run_pkt(-1, 2);
        // 0xA5, 0x3C, then reset part-way through a third byte.
        new_pkt();
        push_byte(8'hA5);
        push_byte(8'h3C);
        for (int i = 0; i < 4; i++) push_raw(1'b1);
        run_pkt(pkt.size(), 0);
        new_pkt();
        push_byte(8'h5A);
        run_pkt(-1, 0);
        // Packet ending inside a pending stuffed bit, then a normal packet.
        load(64'h3F, 6);
        run_pkt(-1, 0);
        new_pkt();
        push_byte(8'hFE);
        push_byte(8'h81);
        run_pkt(-1, 1);
        load(64'h3FF, 10);
        run_pkt(-1, 0);

        for (int p = 0; p < 60; p++) begin
            mode = int'($urandom_range(0, 3));
            new_pkt();
            if (mode <= 1) begin
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    push_byte(($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom));
                end
                len = int'($urandom_range(0, 7));
                for (int b = 0; b < len; b++) push_raw(1'($urandom));
            end else begin
                len = int'($urandom_range(1, 30));
                for (int b = 0; b < len; b++) pkt.push_back($urandom_range(0, 4) != 0);
            end
            if (mode == 3 && $urandom_range(0, 2) == 0)
                run_pkt(int'($urandom_range(0, pkt.size())), int'($urandom_range(0, 2)));
            else
                run_pkt(-1, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
